// File: rtl/lsu_retire_ctrl_pkg.sv
// Shared types for the LSU retirement controller.
// Optional performance counters are enabled with the LSU_RETIRE_PERF_EN macro.
package lsu_retire_ctrl_pkg;

    // Width of every byte-count field (store width, D$ write width, LQ check width)
    localparam int LSU_WIDTH_BITS = 4;

    typedef enum logic {
        LSU_OP_LOAD  = 1'b0,
        LSU_OP_STORE = 1'b1
    } lsu_op_t;

    typedef enum logic [2:0] {
        LSU_IDLE      = 3'd0,
        LSU_LD_RETIRE = 3'd1,
        LSU_ST_READ   = 3'd2,
        LSU_ST_WRITE  = 3'd3,
        LSU_ST_CHECK  = 3'd4,
        LSU_ACK       = 3'd5
    } lsu_retire_state_t;

endpackage

// File: rtl/lsu_retire_ctrl_perf.sv
// Retirement performance counters: loads, stores and mis-speculated loads.
// Counters wrap naturally and are only cleared by reset.
// Instantiated by lsu_retire_ctrl only when LSU_RETIRE_PERF_EN is defined.
module lsu_retire_perf (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        i_ack_ld,
    input  logic        i_ack_st,
    input  logic        i_ack_mis,
    output logic [31:0] o_perf_ld_count,
    output logic [31:0] o_perf_st_count,
    output logic [31:0] o_perf_mis_spec_count
);

    logic [31:0] ld_count_q;
    logic [31:0] st_count_q;
    logic [31:0] mis_count_q;

    // Count each retirement event on the cycle the ROB ack is issued
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ld_count_q  <= '0;
            st_count_q  <= '0;
            mis_count_q <= '0;
        end else begin
            if (i_ack_ld)  ld_count_q  <= ld_count_q + 32'd1;
            if (i_ack_st)  st_count_q  <= st_count_q + 32'd1;
            if (i_ack_mis) mis_count_q <= mis_count_q + 32'd1;
        end
    end

    assign o_perf_ld_count       = ld_count_q;
    assign o_perf_st_count       = st_count_q;
    assign o_perf_mis_spec_count = mis_count_q;

endmodule

// File: rtl/lsu_retire_ctrl.sv
// LSU retirement sequencer: retires one memory op at a time from the ROB head.
// Loads retire their LQ entry and report the mis-speculation bit; stores are
// read from the SQ, written to the D$ (req/ack) and then broadcast to the LQ.
// Define LSU_RETIRE_PERF_EN to add the load/store/mis-spec performance counters.
module lsu_retire_ctrl
    import lsu_retire_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      i_flush,
    input  logic                      i_rob_retire_en,
    input  logic [TAG_WIDTH-1:0]      i_rob_retire_tag,
    input  logic                      i_rob_retire_op,
    output logic                      o_rob_retire_ack,
    output logic                      o_rob_retire_mis_speculated,
    output logic                      o_lq_retire_en,
    output logic [TAG_WIDTH-1:0]      o_lq_retire_tag,
    input  logic                      i_lq_retire_mis_speculated,
    output logic                      o_sq_retire_en,
    output logic [TAG_WIDTH-1:0]      o_sq_retire_tag,
    input  logic [ADDR_WIDTH-1:0]     i_sq_retire_addr,
    input  logic [DATA_WIDTH-1:0]     i_sq_retire_data,
    input  logic [LSU_WIDTH_BITS-1:0] i_sq_retire_width,
    output logic                      o_dc_wr_en,
    output logic [ADDR_WIDTH-1:0]     o_dc_wr_addr,
    output logic [DATA_WIDTH-1:0]     o_dc_wr_data,
    output logic [LSU_WIDTH_BITS-1:0] o_dc_wr_width,
    input  logic                      i_dc_wr_ack,
    output logic                      o_lq_sq_retire_en,
    output logic [ADDR_WIDTH-1:0]     o_lq_sq_retire_addr,
    output logic [LSU_WIDTH_BITS-1:0] o_lq_sq_retire_width,
`ifdef LSU_RETIRE_PERF_EN
    output logic [31:0]               o_perf_ld_count,
    output logic [31:0]               o_perf_st_count,
    output logic [31:0]               o_perf_mis_spec_count,
`endif
    output logic                      o_busy
);

    lsu_retire_state_t         state_q,   state_d;
    logic [TAG_WIDTH-1:0]      tag_q,     tag_d;
    lsu_op_t                   op_q,      op_d;
    logic [ADDR_WIDTH-1:0]     addr_q,    addr_d;
    logic [DATA_WIDTH-1:0]     data_q,    data_d;
    logic [LSU_WIDTH_BITS-1:0] width_q,   width_d;
    logic                      mis_q,     mis_d;
    // Set when a flush lands while a committed store is finishing; suppresses the ROB ack
    logic                      flushed_q, flushed_d;

    // State and latched-operand registers; reset drops any in-flight op and D$ request
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= LSU_IDLE;
            tag_q     <= '0;
            op_q      <= LSU_OP_LOAD;
            addr_q    <= '0;
            data_q    <= '0;
            width_q   <= '0;
            mis_q     <= 1'b0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            width_q   <= width_d;
            mis_q     <= mis_d;
            flushed_q <= flushed_d;
        end
    end

    // Next-state and strobe decode; a flush kills strobes in the cycle it is seen
    // except once the store is committed to the D$
    always_comb begin
        state_d                     = state_q;
        tag_d                       = tag_q;
        op_d                        = op_q;
        addr_d                      = addr_q;
        data_d                      = data_q;
        width_d                     = width_q;
        mis_d                       = mis_q;
        flushed_d                   = flushed_q;
        o_rob_retire_ack            = 1'b0;
        o_rob_retire_mis_speculated = 1'b0;
        o_lq_retire_en              = 1'b0;
        o_sq_retire_en              = 1'b0;
        o_dc_wr_en                  = 1'b0;
        o_lq_sq_retire_en           = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                if (i_rob_retire_en && !i_flush) begin
                    tag_d     = i_rob_retire_tag;
                    op_d      = lsu_op_t'(i_rob_retire_op);
                    flushed_d = 1'b0;
                    state_d   = (lsu_op_t'(i_rob_retire_op) == LSU_OP_STORE) ? LSU_ST_READ
                                                                              : LSU_LD_RETIRE;
                end
            end
            LSU_LD_RETIRE: begin
                if (i_flush) begin
                    state_d = LSU_IDLE;
                end else begin
                    o_lq_retire_en = 1'b1;
                    mis_d          = i_lq_retire_mis_speculated;
                    state_d        = LSU_ACK;
                end
            end
            LSU_ST_READ: begin
                if (i_flush) begin
                    state_d = LSU_IDLE;
                end else begin
                    o_sq_retire_en = 1'b1;
                    addr_d         = i_sq_retire_addr;
                    data_d         = i_sq_retire_data;
                    width_d        = i_sq_retire_width;
                    state_d        = LSU_ST_WRITE;
                end
            end
            LSU_ST_WRITE: begin
                o_dc_wr_en = 1'b1;
                if (i_flush) flushed_d = 1'b1;
                if (i_dc_wr_ack) state_d = LSU_ST_CHECK;
            end
            LSU_ST_CHECK: begin
                o_lq_sq_retire_en = 1'b1;
                state_d = (flushed_q || i_flush) ? LSU_IDLE : LSU_ACK;
            end
            LSU_ACK: begin
                state_d = LSU_IDLE;
                if (!i_flush) begin
                    o_rob_retire_ack            = 1'b1;
                    o_rob_retire_mis_speculated = (op_q == LSU_OP_LOAD) && mis_q;
                end
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    assign o_lq_retire_tag      = tag_q;
    assign o_sq_retire_tag      = tag_q;
    assign o_dc_wr_addr         = addr_q;
    assign o_dc_wr_data         = data_q;
    assign o_dc_wr_width        = width_q;
    assign o_lq_sq_retire_addr  = addr_q;
    assign o_lq_sq_retire_width = width_q;
    assign o_busy               = (state_q != LSU_IDLE);

`ifdef LSU_RETIRE_PERF_EN
    logic perf_ack_ld;
    logic perf_ack_st;

    assign perf_ack_ld = o_rob_retire_ack && (op_q == LSU_OP_LOAD);
    assign perf_ack_st = o_rob_retire_ack && (op_q == LSU_OP_STORE);

    lsu_retire_perf u_perf (
        .clk                   (clk),
        .n_rst                 (n_rst),
        .i_ack_ld              (perf_ack_ld),
        .i_ack_st              (perf_ack_st),
        .i_ack_mis             (o_rob_retire_mis_speculated),
        .o_perf_ld_count       (o_perf_ld_count),
        .o_perf_st_count       (o_perf_st_count),
        .o_perf_mis_spec_count (o_perf_mis_spec_count)
    );
`endif

endmodule

// File: doc/lsu_retire_ctrl.md
Name: lsu_retire_ctrl

Overview:
- Sequences retirement of memory ops from the ROB head into the LSU.
- Loads: retires the LQ entry and returns its mis-speculated bit to the ROB.
- Stores: reads the SQ entry, writes it to the D$ write port (req/ack), then broadcasts the retired store's address and width to the LQ for mis-speculation detection.
- Sits between the ROB, LQ, SQ and D$ write port. Handles one op at a time.

Parameters:
- DATA_WIDTH, 32, store data width
- ADDR_WIDTH, 32, address width
- TAG_WIDTH, 6, ROB tag width

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- i_flush  in  1  pipeline flush
- i_rob_retire_en  in  1  ROB head is a memory op ready to retire; held until ack
- i_rob_retire_tag  in  TAG_WIDTH  ROB tag of the head op
- i_rob_retire_op  in  1  0 = load, 1 = store
- o_rob_retire_ack  out  1  one-cycle retire-done pulse
- o_rob_retire_mis_speculated  out  1  valid with ack; 1 means the load must replay
- o_lq_retire_en  out  1  LQ retire strobe
- o_lq_retire_tag  out  TAG_WIDTH  LQ retire tag
- i_lq_retire_mis_speculated  in  1  LQ mis-spec bit for the tag, combinational
- o_sq_retire_en  out  1  SQ entry read and release strobe
- o_sq_retire_tag  out  TAG_WIDTH  SQ tag
- i_sq_retire_addr  in  ADDR_WIDTH  SQ store address, combinational
- i_sq_retire_data  in  DATA_WIDTH  SQ store data, combinational
- i_sq_retire_width  in  4  SQ store width in bytes (1, 2, 4)
- o_dc_wr_en  out  1  D$ write request
- o_dc_wr_addr  out  ADDR_WIDTH  D$ write address
- o_dc_wr_data  out  DATA_WIDTH  D$ write data
- o_dc_wr_width  out  4  D$ write width in bytes
- i_dc_wr_ack  in  1  D$ write accepted
- o_lq_sq_retire_en  out  1  mis-spec check strobe to the LQ
- o_lq_sq_retire_addr  out  ADDR_WIDTH  retired store address
- o_lq_sq_retire_width  out  4  retired store width
- o_busy  out  1  state is not IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; internal latches (tag, op, addr, data, width, mis-spec) cleared.
- FSM states: IDLE, LD_RETIRE, ST_READ, ST_WRITE, ST_CHECK, ACK.
- IDLE: when i_rob_retire_en && !i_flush, latch tag and op. Load goes to LD_RETIRE; store goes to ST_READ.
- LD_RETIRE (1 cycle): o_lq_retire_en=1 with the latched tag; register i_lq_retire_mis_speculated; go to ACK.
- ST_READ (1 cycle): o_sq_retire_en=1 with the latched tag; latch addr, data and width; go to ST_WRITE.
- ST_WRITE: o_dc_wr_en held high with stable addr, data and width until i_dc_wr_ack is sampled high. Ack may arrive in the first ST_WRITE cycle. Then go to ST_CHECK.
- ST_CHECK (1 cycle): o_lq_sq_retire_en=1 with the latched addr and width; go to ACK.
- ACK (1 cycle): o_rob_retire_ack=1. o_rob_retire_mis_speculated = latched bit for loads, 0 for stores. Go to IDLE.
- Latency, accept cycle = 0:
  - load ack at cycle 2;
  - store ack at cycle 4 plus extra ST_WRITE wait cycles.
- i_rob_retire_en is ignored outside IDLE. The ROB must drop it in the cycle after ack, so the next accept is at the earliest 1 cycle after ACK.
- All strobes are single-cycle pulses, never asserted in two consecutive cycles.
- Flush:
  - In IDLE, LD_RETIRE or ACK: go to IDLE immediately. No ack, and no strobe in the flush cycle.
  - In ST_READ: go to IDLE; o_sq_retire_en is suppressed.
  - In ST_WRITE or ST_CHECK: the store is already committed, so it continues through ST_CHECK and then goes to IDLE with no ROB ack.
- Reset mid-operation: returns to IDLE asynchronously. Any outstanding D$ request is dropped.

Optional Feature:
- Macro LSU_RETIRE_PERF_EN.
- Defined: adds outputs o_perf_ld_count, o_perf_st_count and o_perf_mis_spec_count, each 32 bits.
  - Incremented on ACK for a load, on ACK for a store, and on ACK with mis_speculated=1, respectively.
  - Wrap at 2^32. Cleared by reset. Not cleared by flush.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- types package:
  - lsu_op_t enum (LSU_OP_LOAD=0, LSU_OP_STORE=1);
  - lsu_retire_state_t enum of the six states;
  - constant LSU_WIDTH_BITS=4.
- Sub-module lsu_retire_perf holds the three counters; instantiated only under LSU_RETIRE_PERF_EN.

Test Plan:
- Load retire: tag=5, op=0, LQ mis-spec=0 -> o_lq_retire_en at cycle 1 with tag 5; ack at cycle 2 with mis_speculated=0.
- Mis-speculated load: tag=9, LQ returns 1 -> ack at cycle 2 with mis_speculated=1; perf mis-spec count = 1 when the macro is defined.
- Store with D$ stall: SQ addr=0x1000, data=0xDEADBEEF, width=4; ack withheld 3 cycles -> o_dc_wr_en stable for 3 cycles with those values; o_lq_sq_retire_en with addr 0x1000 / width 4 one cycle after ack; ROB ack at cycle 7.
- Flush during ST_WRITE: flush raised in the second stall cycle -> write completes and the LQ check pulses; no ROB ack; o_busy=0 afterwards.
- Flush in LD_RETIRE -> no LQ strobe, no ack; back-to-back retire accepted the next cycle after flush deasserts.
- Async reset asserted during ST_WRITE -> all outputs 0 immediately; state IDLE after n_rst releases.
